// File: rtl/bp_pkg.sv
// Package: bp_pkg
// Purpose: shared types and helpers for the pattern history table controller.
//   ctr_t       - 2-bit saturating branch counter
//   CTR_*       - named counter values (strong/weak, not-taken/taken)
//   state_t     - controller state (idle / table sweep)
//   ctr_update  - saturating increment on taken, decrement on not-taken
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        ctr_t r;
        if (taken) begin
            r = (c == CTR_ST) ? CTR_ST : c + 2'd1;
        end else begin
            r = (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Module: bp_upd_fifo
// Purpose: small synchronous FIFO holding resolved branches {idx, taken}
//          until the table has a free slot to absorb them.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_push     write i_data at the tail
//   i_pop      retire the head entry (caller guarantees non-empty)
//   i_clear    empty the FIFO; overrides push and pop
//   i_data     entry to write
//   o_data     current head entry (valid when o_count != 0)
//   o_count    occupancy, 0..DEPTH
module bp_upd_fifo #(
    parameter  int DW    = 5,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [DW-1:0]    i_data,
    output logic [DW-1:0]    o_data,
    output logic [CNT_W-1:0] o_count
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The head is read combinationally so the drain can finish its
    // read-modify-write of the table in a single cycle.
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/bp_pht_ctrl.sv
// Module: bp_pht_ctrl
// Purpose: controller for a table of 2-bit saturating branch counters.
//   One table access per cycle, shared by: sweep write (flush) > predict
//   read > drain of the update FIFO. Resolved branches queue in the FIFO
//   and are written back whenever no prediction claims the slot.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_pred_req/idx    predict request and table index
//   o_pred_ready      predict accepted when i_pred_req && o_pred_ready
//   o_pred_valid      one-cycle pulse, o_pred_taken valid
//   o_pred_taken      prediction (counter msb), holds between pulses
//   i_upd_valid/idx/taken  resolved branch offered
//   o_upd_ready       update pushed when i_upd_valid && o_upd_ready
//   i_flush           one-cycle pulse starting a table sweep
//   o_busy            sweep in progress
//   o_upd_count       update FIFO occupancy
module bp_pht_ctrl
    import bp_pkg::*;
#(
    parameter  int   IDX_W      = 4,
    parameter  int   FIFO_DEPTH = 4,
    parameter  ctr_t INIT_CTR   = CTR_WNT,
    localparam int   CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pred_req,
    input  logic [IDX_W-1:0] i_pred_idx,
    output logic             o_pred_ready,
    output logic             o_pred_valid,
    output logic             o_pred_taken,
    input  logic             i_upd_valid,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    output logic             o_upd_ready,
    input  logic             i_flush,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_upd_count
);

    localparam int ENTRIES = 2 ** IDX_W;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_sweep_idx;
    logic                 r_pred_valid;
    logic                 r_pred_taken;

    logic [2*ENTRIES-1:0] w_table;
    logic [ENTRIES-1:0]   w_wr_en;
    ctr_t                 w_wr_data;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pred_acc;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_clear;

    logic [IDX_W:0]       w_head;
    logic [IDX_W-1:0]     w_head_idx;
    logic                 w_head_taken;
    ctr_t                 w_drain_old;
    ctr_t                 w_drain_new;
    logic [CNT_W-1:0]     w_count;

    bp_upd_fifo #(
        .DW    (IDX_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  ({i_upd_idx, i_upd_taken}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign {w_head_idx, w_head_taken} = w_head;
    assign w_full  = (w_count == CNT_W'(FIFO_DEPTH));
    assign w_empty = (w_count == '0);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A full FIFO drops both readies, so the predict port cannot win the
    // slot and the drain is guaranteed to make progress that cycle.
    always_comb begin
        w_state_next = r_state;
        o_pred_ready = 1'b0;
        o_upd_ready  = 1'b0;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_flush) begin
                    w_state_next = ST_FLUSH;
                    w_clear      = 1'b1;
                end else begin
                    o_pred_ready = !w_full;
                    o_upd_ready  = !w_full;
                    w_pop        = !w_empty && !(i_pred_req && !w_full);
                end
            end
            ST_FLUSH: begin
                if (r_sweep_idx == IDX_W'(ENTRIES - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_pred_acc = i_pred_req && o_pred_ready;
    assign w_push     = i_upd_valid && o_upd_ready;
    assign o_busy     = (r_state == ST_FLUSH);

    // Sweep index sits at 0 while idle so every sweep starts from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep_idx <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_sweep_idx <= r_sweep_idx + IDX_W'(1);
        end else begin
            r_sweep_idx <= '0;
        end
    end

    // ---------------- counter table ----------------
    assign w_drain_old = w_table[{w_head_idx, 1'b0} +: 2];
    assign w_drain_new = ctr_update(w_drain_old, w_head_taken);
    assign w_wr_data   = (r_state == ST_FLUSH) ? INIT_CTR : w_drain_new;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            ctr_t r_ctr;

            assign w_wr_en[gi] = (r_state == ST_FLUSH)
                               ? (r_sweep_idx == IDX_W'(gi))
                               : (w_pop && (w_head_idx == IDX_W'(gi)));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ctr <= INIT_CTR;
                end else if (w_wr_en[gi]) begin
                    r_ctr <= w_wr_data;
                end
            end

            assign w_table[2*gi +: 2] = r_ctr;
        end
    endgenerate

    // ---------------- predict output ----------------
    // The taken bit is the counter msb, i.e. bit {idx,1} of the flat table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
        end else begin
            r_pred_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_taken <= w_table[{i_pred_idx, 1'b1}];
            end
        end
    end

    assign o_pred_valid = r_pred_valid;
    assign o_pred_taken = r_pred_taken;
    assign o_upd_count  = w_count;

endmodule
